// File: rtl/md_stall_ctrl_if.sv
// Signal bundle between the multiply/divide sequencing controller and the
// surrounding pipeline.
// The controller side uses the master modport. The pipeline side (decode
// registers, hazard unit, MD datapath) uses the slave modport.
interface md_stall_ctrl_if;
  logic [31:0] IR_D;      // instruction in D stage
  logic [31:0] IR_E;      // instruction in E stage
  logic        stall_in;  // load-use / branch hazard stall request
  logic        md_start;  // single-cycle start pulse to the MD unit
  logic [1:0]  md_op;     // 00 mult, 01 multu, 10 div, 11 divu
  logic        md_done;   // HI/LO write enable, last busy cycle
  logic        busy;      // MD unit occupied
  logic        stall_PC;  // hold PC
  logic        stall_D;   // hold F/D register
  logic        flush_E;   // bubble into D/E register

  modport master (
    input  IR_D, IR_E, stall_in,
    output md_start, md_op, md_done, busy, stall_PC, stall_D, flush_E
  );

  modport slave (
    output IR_D, IR_E, stall_in,
    input  md_start, md_op, md_done, busy, stall_PC, stall_D, flush_E
  );
endinterface

// File: rtl/md_stall_ctrl.sv
// Sequencing controller for the shared multi-cycle HI/LO multiply/divide
// unit. It starts the unit from the E stage and counts down the busy
// time. While a HI/LO consumer in D must wait, it freezes PC/D and
// bubbles E. It also folds in the external hazard stall, so the pipeline
// has one stall/flush source.
module md_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  md_stall_ctrl_if.master   bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FN_MFHI    = 6'b010000;
  localparam logic [5:0] FN_MTHI    = 6'b010001;
  localparam logic [5:0] FN_MFLO    = 6'b010010;
  localparam logic [5:0] FN_MTLO    = 6'b010011;
  localparam logic [5:0] FN_MULT    = 6'b011000;
  localparam logic [5:0] FN_MULTU   = 6'b011001;
  localparam logic [5:0] FN_DIV     = 6'b011010;
  localparam logic [5:0] FN_DIVU    = 6'b011011;

  // The counter is loaded with N-1, so the final (done) cycle is the one
  // where it reads zero.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  // Decode helpers: opcode SPECIAL plus the listed functs. A nop is
  // SPECIAL/SLL, so it is non-MD without a special case.
  function automatic logic is_md_op(input logic [31:0] ir);
    return (ir[31:26] == OP_SPECIAL) &&
           ((ir[5:0] == FN_MULT) || (ir[5:0] == FN_MULTU) ||
            (ir[5:0] == FN_DIV)  || (ir[5:0] == FN_DIVU));
  endfunction

  function automatic logic is_hilo_move(input logic [31:0] ir);
    return (ir[31:26] == OP_SPECIAL) &&
           ((ir[5:0] == FN_MFHI) || (ir[5:0] == FN_MTHI) ||
            (ir[5:0] == FN_MFLO) || (ir[5:0] == FN_MTLO));
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q;
  logic             done_q;

  logic             md_e;
  logic             uses_md_d;
  logic             start;
  logic             md_stall;
  logic [CNT_W-1:0] cnt_load;

  // Instruction decode, start qualification and stall merge.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch.
    // A path that leaves a signal unassigned would infer a latch.
    md_e      = 1'b0;
    uses_md_d = 1'b0;
    start     = 1'b0;
    md_stall  = 1'b0;
    cnt_load  = MULT_LOAD;

    md_e      = is_md_op(bus.IR_E);
    uses_md_d = is_md_op(bus.IR_D) || is_hilo_move(bus.IR_D);

    // The stall keeps a second MD op out of E while RUN, so IDLE gating
    // only makes that invariant explicit.
    start     = (state == IDLE) && md_e;

    // Stall on start as well as busy. This catches the HI/LO consumer
    // that directly follows the MD op, one cycle before busy rises.
    md_stall  = uses_md_d && (busy_q || start);

    cnt_load  = bus.IR_E[1] ? DIV_LOAD : MULT_LOAD;
  end

  // IDLE/RUN sequencer with busy-time down-counter. busy and done are
  // registered. done is pre-computed one cycle ahead, so it is high
  // exactly in the cycle the counter reads zero.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous. It is sampled only on the rising
    // edge, so a mid-operation reset drops the run at that edge.
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments. All of them
      // then update together from pre-edge values, with no ordering race.
      case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            cnt    <= cnt_load;
            busy_q <= 1'b1;
            done_q <= (cnt_load == '0);
          end else begin
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
          end else begin
            cnt    <= cnt - 1'b1;
            busy_q <= 1'b1;
            done_q <= (cnt == CNT_W'(1));
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs. The stall controls are combinational so the freeze applies
  // in the same cycle as the hazard.
  assign bus.md_start = start;
  assign bus.md_op    = bus.IR_E[1:0];
  assign bus.md_done  = done_q;
  assign bus.busy     = busy_q;
  assign bus.stall_PC = md_stall || bus.stall_in;
  assign bus.stall_D  = md_stall || bus.stall_in;
  assign bus.flush_E  = md_stall || bus.stall_in;

endmodule

// File: tb/tb_md_stall_ctrl.sv
// Directed bench for md_stall_ctrl with MULT=5 and DIV=10 busy cycles.
// Inputs change 1 time unit after the rising edge. Outputs are sampled
// on the falling edge of the same cycle.
module tb_md_stall_ctrl;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] MULT  = 32'h0085_0018;
  localparam logic [31:0] MULTU = 32'h0085_0019;
  localparam logic [31:0] DIV   = 32'h0085_001A;
  localparam logic [31:0] DIVU  = 32'h0085_001B;
  localparam logic [31:0] MFHI  = 32'h0000_8010;
  localparam logic [31:0] MFLO  = 32'h0000_1012;
  localparam logic [31:0] MTLO  = 32'h0080_0013;
  localparam logic [31:0] ADDU  = 32'h0085_1021;
  localparam logic [31:0] ADDI_MDFN = 32'h2085_0018; // non-SPECIAL, MULT funct

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  md_stall_ctrl_if bus ();

  md_stall_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle, apply inputs, then wait for the sample point.
  task automatic cyc(input logic [31:0] ir_d, input logic [31:0] ir_e,
                     input logic st);
    @(posedge clk);
    #1;
    bus.IR_D     = ir_d;
    bus.IR_E     = ir_e;
    bus.stall_in = st;
    @(negedge clk);
  endtask

  // Check start/busy/done and all three stall outputs.
  task automatic outs(input string tag, input logic start, input logic bsy,
                      input logic done, input logic stl);
    check({tag, ".start"},    32'(bus.md_start), 32'(start));
    check({tag, ".busy"},     32'(bus.busy),     32'(bsy));
    check({tag, ".done"},     32'(bus.md_done),  32'(done));
    check({tag, ".stall_PC"}, 32'(bus.stall_PC), 32'(stl));
    check({tag, ".stall_D"},  32'(bus.stall_D),  32'(stl));
    check({tag, ".flush_E"},  32'(bus.flush_E),  32'(stl));
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.IR_D     = NOP;
    bus.IR_E     = NOP;
    bus.stall_in = 1'b0;
    cyc(NOP, NOP, 1'b0);
    cyc(NOP, NOP, 1'b0);
    rst_n = 1'b1;

    // Reset state with nops.
    cyc(NOP, NOP, 1'b0);
    outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);

    // MULT in E, MFLO in D: stall t..t+5, done at t+5.
    cyc(MFLO, MULT, 1'b0);
    outs("mult.t0", 1'b1, 1'b0, 1'b0, 1'b1);
    check("mult.op", 32'(bus.md_op), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      cyc(MFLO, NOP, 1'b0);
      outs($sformatf("mult.t%0d", k), 1'b0, 1'b1, (k == 5), 1'b1);
    end
    cyc(MFLO, NOP, 1'b0);
    outs("mult.t6", 1'b0, 1'b0, 1'b0, 1'b0);

    // DIVU in E, ADDU in D: no MD stall; external stall during the run.
    cyc(ADDU, DIVU, 1'b0);
    outs("divu.t0", 1'b1, 1'b0, 1'b0, 1'b0);
    check("divu.op", 32'(bus.md_op), 32'd3);
    for (int k = 1; k <= 10; k++) begin
      cyc(NOP, ADDU, (k >= 3 && k <= 5));
      outs($sformatf("divu.t%0d", k), 1'b0, 1'b1, (k == 10),
           (k >= 3 && k <= 5));
    end
    cyc(NOP, NOP, 1'b0);
    outs("divu.t11", 1'b0, 1'b0, 1'b0, 1'b0);

    // Back-to-back: DIV in E, MULT held in D until the DIV completes.
    cyc(MULT, DIV, 1'b0);
    outs("b2b.t0", 1'b1, 1'b0, 1'b0, 1'b1);
    check("b2b.op_div", 32'(bus.md_op), 32'd2);
    for (int k = 1; k <= 10; k++) begin
      cyc(MULT, NOP, 1'b0);
      outs($sformatf("b2b.t%0d", k), 1'b0, 1'b1, (k == 10), 1'b1);
    end
    cyc(NOP, MULT, 1'b0);
    outs("b2b.t11", 1'b1, 1'b0, 1'b0, 1'b0);
    check("b2b.op_mult", 32'(bus.md_op), 32'd0);
    for (int k = 12; k <= 16; k++) begin
      cyc(NOP, NOP, 1'b0);
      outs($sformatf("b2b.t%0d", k), 1'b0, 1'b1, (k == 16), 1'b0);
    end
    cyc(NOP, NOP, 1'b0);
    outs("b2b.t17", 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-MULTU: rst_n low in cycle t+2, so it is idle from t+3.
    cyc(NOP, MULTU, 1'b0);
    outs("rst.t0", 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst.op", 32'(bus.md_op), 32'd1);
    cyc(MFHI, NOP, 1'b0);
    outs("rst.t1", 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(MFHI, NOP, 1'b0);
    rst_n = 1'b0;
    outs("rst.t2", 1'b0, 1'b1, 1'b0, 1'b1);
    cyc(MFHI, NOP, 1'b0);
    rst_n = 1'b1;
    outs("rst.t3", 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 4; k <= 8; k++) begin
      cyc(NOP, NOP, 1'b0);
      outs($sformatf("rst.t%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // External stall while idle: stall outputs high, FSM untouched.
    cyc(NOP, NOP, 1'b1);
    outs("ext.t0", 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(NOP, NOP, 1'b0);
    outs("ext.t1", 1'b0, 1'b0, 1'b0, 1'b0);

    // Decode boundaries: non-SPECIAL opcode with MULT funct is not MD;
    // an HI/LO move in D with the unit idle does not stall.
    cyc(ADDI_MDFN, ADDI_MDFN, 1'b0);
    outs("dec.addi", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(MTLO, NOP, 1'b0);
    outs("dec.mtlo_idle", 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(NOP, NOP, 1'b0);
    outs("dec.after", 1'b0, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_stall_ctrl.md
Name: md_stall_ctrl

Overview:
- Sequencing controller for the shared multi-cycle multiply/divide unit (HI/LO) in the 5-stage MIPS32 pipeline.
- Decodes the E-stage instruction and issues a start pulse to the unit when that instruction is MULT/MULTU/DIV/DIVU.
- Tracks busy time with a down-counter.
- Raises a freeze of PC/D and a flush of E while a D-stage HI/LO instruction must wait.
- Merges the external hazard stall, so the result is the single pipeline stall/flush source.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)-1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- IR_D  in  32  instruction in D stage.
- IR_E  in  32  instruction in E stage.
- stall_in  in  1  stall request from the load-use/branch hazard logic.
- md_start  out  1  one-cycle start pulse to the MD unit (combinational).
- md_op  out  2  op to the MD unit, = IR_E[1:0]: 00 mult, 01 multu, 10 div, 11 divu. Valid only with md_start.
- md_done  out  1  HI/LO write enable for the MD unit, asserted in the last busy cycle.
- busy  out  1  MD unit occupied (registered state).
- stall_PC  out  1  hold PC.
- stall_D  out  1  hold the F/D pipeline register.
- flush_E  out  1  load a NOP into the D/E pipeline register.

Behaviour:
- Decode (opcode IR[31:26]==6'b000000):
  - md_E = IR_E funct is 011000, 011001, 011010 or 011011.
  - uses_md_D = IR_D funct is one of: those four, or 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo.
  - All other opcodes/functs are non-MD; IR==0 (nop) is non-MD.
- States:
  - IDLE: busy=0, cnt=0.
  - RUN: busy=1.
- md_start = (state==IDLE) & md_E. A start is never accepted in RUN; by construction the stall prevents that case.
- IDLE & md_start -> RUN at the next edge.
  - cnt <= MULT_CYCLES-1 when IR_E[1]==0.
  - cnt <= DIV_CYCLES-1 when IR_E[1]==1.
- RUN:
  - cnt==0 -> IDLE, with md_done=1 during that cycle.
  - otherwise cnt <= cnt-1 and md_done=0.
- Timing, with md_start at cycle t and N the busy count:
  - busy=1 for cycles t+1..t+N.
  - md_done=1 exactly at cycle t+N.
  - busy=0 at t+N+1.
- md_stall = uses_md_D & (busy | md_start). This stalls the HI/LO consumer that directly follows the start.
- stall_PC = stall_D = flush_E = md_stall | stall_in. All three are combinational, with no registered delay.
- The E stage is never held. The MD instruction leaves E after one cycle, so md_start is always a single-cycle pulse.
- stall_in has no effect on the FSM or counter; a running operation continues through external stalls.
- Back-to-back operations: a second MULT/DIV in D is stalled until busy=0. It reaches E and starts at the first IDLE cycle, with no bubble beyond the stall.
- Reset:
  - rst_n=0 at any edge forces IDLE and cnt=0, including mid-operation. The partial result is discarded.
  - Reset values: busy=0, md_done=0. md_start, stall_* and flush_E follow the inputs only (0 when IR_D/IR_E are nops and stall_in=0).
- md_op is don't-care when md_start=0; the bench checks it only with md_start.

Test Plan:
- Reset, then nops with stall_in=0 -> busy=0, md_done=0, md_start=0, stall_PC=stall_D=flush_E=0.
- IR_E=MULT (0x00850018) at t, IR_D=MFLO (0x00001012):
  - md_start=1 and md_op=00 at t.
  - stall_* = 1 for t..t+5 (6 cycles).
  - md_done=1 at t+5; stall=0 at t+6.
- IR_E=DIVU at t, IR_D=ADDU (non-MD):
  - md_op=11 at t.
  - stall=0 throughout, busy=1 for t+1..t+10, md_done at t+10.
- IR_E=DIV at t, IR_D=MULT (back-to-back):
  - stall_* = 1 for t..t+10.
  - Second MULT in E at t+11: md_start=1 there, busy again t+12..t+16.
- MULT starts, rst_n=0 at edge t+2 -> busy=0 from t+3, no md_done, and an MFHI in D unstalls immediately.
- stall_in=1 with busy=0 -> all three stall outputs = 1 and the FSM is unchanged. Also stall_in during RUN -> cnt still decrements and md_done still fires at t+N.
